// File: rtl/mem_copy_engine.sv
// ============================================================================
// mem_copy_engine
// ----------------------------------------------------------------------------
// Copies len_in consecutive words from a source word address to a destination
// word address over a single-port memory interface. Each word takes two
// cycles: a READ cycle (the memory returns data combinationally, latched into
// a one-word buffer at the end of the cycle) followed by a WRITE cycle that
// presents the buffered word at the destination address.
//
// Every output is a flop. The memory-port, busy and done flops are loaded
// from the *next* state and datapath values. An output therefore reflects the
// state the engine is in during that cycle, and there is no combinational
// path from any input to any output.
//
// Ports
//   clock            in   single clock, all state changes on rising edge
//   reset            in   synchronous active-high reset
//   start_in         in   request a copy (sampled only while idle)
//   abort_in         in   cancel the copy in progress (READ/WRITE only)
//   src_addr_in      in   first source word address   (captured on start)
//   dst_addr_in      in   first destination word addr (captured on start)
//   len_in           in   number of words to copy     (captured on start)
//   busy_out         out  high while reading or writing
//   done_out         out  one-cycle pulse on normal completion
//   words_done_out   out  words written in the current / last transfer
//   mem_enable_out   out  memory port enable
//   mem_wb_out       out  0 = read, 1 = write
//   mem_addr_out     out  memory word address
//   mem_data_out     out  write data
//   mem_data_in      in   read data, valid in the same cycle as the address
// ============================================================================
module mem_copy_engine #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int ADDR_WIDTH       = 16,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_in,
    input  logic                        abort_in,
    input  logic [ADDR_WIDTH-1:0]       src_addr_in,
    input  logic [ADDR_WIDTH-1:0]       dst_addr_in,
    input  logic [LEN_WIDTH-1:0]        len_in,
    output logic                        busy_out,
    output logic                        done_out,
    output logic [LEN_WIDTH-1:0]        words_done_out,
    output logic                        mem_enable_out,
    output logic                        mem_wb_out,
    output logic [ADDR_WIDTH-1:0]       mem_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [ADDR_WIDTH-1:0]       ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]        LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]        LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MEMORY_BUS_WIDTH-1:0] DATA_ZERO = {MEMORY_BUS_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Base plus word index, wrapping modulo 2^ADDR_WIDTH. The index is
    // resized to the address width first, so a length field wider than the
    // address simply wraps around the address space.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [LEN_WIDTH-1:0]  index
    );
        logic [ADDR_WIDTH-1:0] index_a;
        index_a = ADDR_WIDTH'(index);
        return base + index_a;
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                        state_q,      state_d;
    logic [ADDR_WIDTH-1:0]         src_q,        src_d;
    logic [ADDR_WIDTH-1:0]         dst_q,        dst_d;
    logic [LEN_WIDTH-1:0]          len_q,        len_d;
    logic [LEN_WIDTH-1:0]          idx_q,        idx_d;
    logic [LEN_WIDTH-1:0]          words_done_q, words_done_d;
    logic [MEMORY_BUS_WIDTH-1:0]   buf_q,        buf_d;

    // Registered outputs
    logic                          busy_q,       busy_d;
    logic                          done_q,       done_d;
    logic                          mem_en_q,     mem_en_d;
    logic                          mem_wb_q,     mem_wb_d;
    logic [ADDR_WIDTH-1:0]         mem_addr_q,   mem_addr_d;
    logic [MEMORY_BUS_WIDTH-1:0]   mem_data_q,   mem_data_d;

    logic [LEN_WIDTH-1:0]          idx_inc_s;

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    // Sequences IDLE -> (READ -> WRITE)* -> DONE -> IDLE, capturing the
    // request on start and stepping the word index after each write.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        idx_d        = idx_q;
        words_done_d = words_done_q;
        buf_d        = buf_q;
        idx_inc_s    = idx_q + LEN_ONE;

        case (state_q)
            ST_IDLE: begin
                // abort_in is not looked at here, so start wins when both
                // are high.
                if (start_in) begin
                    src_d        = src_addr_in;
                    dst_d        = dst_addr_in;
                    len_d        = len_in;
                    idx_d        = LEN_ZERO;
                    words_done_d = LEN_ZERO;
                    if (len_in == LEN_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_READ: begin
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else begin
                    buf_d   = mem_data_in;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // An abort leaves index and words_done untouched. The write
                // presented in this cycle is treated as not having completed.
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d        = idx_inc_s;
                    words_done_d = words_done_q + LEN_ONE;
                    if (idx_inc_s == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_DONE: begin
                // start_in and abort_in are both ignored here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state
    // ------------------------------------------------------------------------
    // Loads the output flops with the values belonging to the state being
    // entered, so each output lines up with the cycle spent in that state.
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mem_en_d   = 1'b0;
        mem_wb_d   = 1'b0;
        mem_addr_d = ADDR_ZERO;
        mem_data_d = DATA_ZERO;

        case (state_d)
            ST_READ: begin
                busy_d     = 1'b1;
                mem_en_d   = 1'b1;
                mem_wb_d   = 1'b0;
                mem_addr_d = word_addr(src_d, idx_d);
            end

            ST_WRITE: begin
                busy_d     = 1'b1;
                mem_en_d   = 1'b1;
                mem_wb_d   = 1'b1;
                mem_addr_d = word_addr(dst_d, idx_d);
                mem_data_d = buf_d;
            end

            ST_DONE: begin
                done_d = 1'b1;
            end

            ST_IDLE: begin
                busy_d = 1'b0;
            end

            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Synchronous reset clears everything and takes priority over start/abort.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            src_q        <= ADDR_ZERO;
            dst_q        <= ADDR_ZERO;
            len_q        <= LEN_ZERO;
            idx_q        <= LEN_ZERO;
            words_done_q <= LEN_ZERO;
            buf_q        <= DATA_ZERO;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wb_q     <= 1'b0;
            mem_addr_q   <= ADDR_ZERO;
            mem_data_q   <= DATA_ZERO;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            words_done_q <= words_done_d;
            buf_q        <= buf_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_en_q     <= mem_en_d;
            mem_wb_q     <= mem_wb_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output ports
    // ------------------------------------------------------------------------
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign words_done_out = words_done_q;
    assign mem_enable_out = mem_en_q;
    assign mem_wb_out     = mem_wb_q;
    assign mem_addr_out   = mem_addr_q;
    assign mem_data_out   = mem_data_q;

endmodule
